mux_2_1: RTL and testbench

//   Registered 2:1 multiplexer. Selects one of two WIDTH-bit data lanes packed

---
 rtl/mux_2_1_pkg.sv | 13 +
 rtl/mux_2_1_comb.sv | 21 ++
 rtl/mux_2_1.sv | 46 ++++
 tb/tb_mux_2_1.sv | 137 +++++++++++++
 4 files changed

// File: rtl/mux_2_1_pkg.sv
// Shared constants and helpers for the registered 2:1 lane multiplexer.
package mux_2_1_pkg;

    // Lane select encodings
    localparam logic SEL_LANE0 = 1'b0;
    localparam logic SEL_LANE1 = 1'b1;

    // LSB position of a lane inside the packed input bus
    function automatic int unsigned lane_lsb(input int unsigned width, input logic lane);
        return (lane == SEL_LANE1) ? width : 0;
    endfunction

endpackage : mux_2_1_pkg

// File: rtl/mux_2_1_comb.sv
// Purely combinational WIDTH-bit 2:1 select; all lane bits steered together.
module mux_2_1_comb
    import mux_2_1_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] lane0,
    input  logic [WIDTH-1:0] lane1,
    input  logic             sel,
    output logic [WIDTH-1:0] y_c
);

    // Whole-lane select
    always_comb begin
        y_c = lane0;
        if (sel == SEL_LANE1) begin
            y_c = lane1;
        end
    end

endmodule : mux_2_1_comb

// File: rtl/mux_2_1.sv
// Registered 2:1 multiplexer: selects a lane of the packed input bus onto y
// one clock after sampling; y comes straight from a flop.
module mux_2_1
    import mux_2_1_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH-1:0] i,
    input  logic               sel,
    output logic [WIDTH-1:0]   y
);

    localparam int unsigned LANE0_LSB = lane_lsb(WIDTH, SEL_LANE0);
    localparam int unsigned LANE1_LSB = lane_lsb(WIDTH, SEL_LANE1);

    logic [WIDTH-1:0] lane0;
    logic [WIDTH-1:0] lane1;
    logic [WIDTH-1:0] y_c;

    // Unpack the two lanes from the input bus
    always_comb begin
        lane0 = i[LANE0_LSB +: WIDTH];
        lane1 = i[LANE1_LSB +: WIDTH];
    end

    mux_2_1_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .lane0 (lane0),
        .lane1 (lane1),
        .sel   (sel),
        .y_c   (y_c)
    );

    // Output register; synchronous reset has priority over the data path
    always_ff @(posedge clk) begin
        if (rst) begin
            y <= '0;
        end else begin
            y <= y_c;
        end
    end

endmodule : mux_2_1

// File: tb/tb_mux_2_1.sv
// Directed self-checking bench for mux_2_1 at WIDTH=1 and WIDTH=8.
module tb_mux_2_1;

    logic        clk;
    logic        rst;
    logic [1:0]  i1;
    logic        sel1;
    logic [0:0]  y1;
    logic [15:0] i8;
    logic        sel8;
    logic [7:0]  y8;

    int errors;
    int checks;

    mux_2_1 #(.WIDTH(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .i   (i1),
        .sel (sel1),
        .y   (y1)
    );

    mux_2_1 #(.WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .i   (i8),
        .sel (sel8),
        .y   (y8)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] vv;
        logic       e;
        int         k;

        errors = 0;
        checks = 0;
        rst  = 1'b1;
        i1   = 2'b11;
        sel1 = 1'b1;
        i8   = 16'hFFFF;
        sel8 = 1'b1;

        // Reset held for two edges with inputs that would otherwise give 1
        step();
        check("reset_edge1", 8'(y1), 8'h00);
        check("reset_edge1_w8", y8, 8'h00);
        step();
        check("reset_edge2", 8'(y1), 8'h00);
        rst = 1'b0;

        // Exhaustive WIDTH=1
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < 4; v++) begin
                vv   = 2'(v);
                sel1 = 1'(s);
                i1   = vv;
                e    = (s == 0) ? vv[0] : vv[1];
                step();
                check($sformatf("exh_s%0d_i%0d", s, v), 8'(y1), 8'(e));
            end
        end

        // Latency: mid-cycle input change does not reach y until next edge
        sel1 = 1'b0;
        i1   = 2'b01;
        step();
        check("lat_load", 8'(y1), 8'h01);
        #3;
        i1 = 2'b10;
        #1;
        check("lat_hold", 8'(y1), 8'h01);
        step();
        check("lat_next", 8'(y1), 8'h00);

        // Reset mid-stream, then immediate reload
        i1   = 2'b10;
        sel1 = 1'b1;
        step();
        check("mid_pre", 8'(y1), 8'h01);
        rst = 1'b1;
        step();
        check("mid_rst", 8'(y1), 8'h00);
        rst = 1'b0;
        step();
        check("mid_post", 8'(y1), 8'h01);

        // Integer value 2 truncates to sel=0
        k    = 2;
        i1   = 2'b01;
        sel1 = 1'(k);
        step();
        check("sel_trunc_a", 8'(y1), 8'h01);
        i1 = 2'b10;
        step();
        check("sel_trunc_b", 8'(y1), 8'h00);

        // WIDTH=8 lanes
        i8   = 16'hA55A;
        sel8 = 1'b0;
        step();
        check("w8_lane0", y8, 8'h5A);
        sel8 = 1'b1;
        step();
        check("w8_lane1", y8, 8'hA5);
        i8   = 16'h3C81;
        sel8 = 1'b0;
        step();
        check("w8_lane0b", y8, 8'h81);
        sel8 = 1'b1;
        step();
        check("w8_lane1b", y8, 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mux_2_1
